// File: rtl/pi_result_tx.sv
// Sends a classifier result frame to the Pi over the GPIO byte bus, using a 4-phase strobe/ack handshake.
// The trailing checksum byte is sent only when PI_RESULT_TX_CHECKSUM_EN is defined; the frame holds off until the Pi acks each byte.
module pi_result_tx #(
  parameter int unsigned SETUP_CYCLES   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 500000,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic        fpga_clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  result,
  input  logic [4:0]  num_transitions,
  input  logic [31:0] sum_left,
  input  logic        pi_ack,
  output logic [7:0]  byte_output,
  output logic        tx_strobe,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);

`ifdef PI_RESULT_TX_CHECKSUM_EN
  localparam int unsigned N_BYTES = 8;
`else
  localparam int unsigned N_BYTES = 7;
`endif
  localparam logic [2:0]  LAST_IDX = 3'(N_BYTES - 1);
  localparam int unsigned CNT_MAX  = (SETUP_CYCLES > TIMEOUT_CYCLES) ? SETUP_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, LOAD, SETUP, WAIT_HI, WAIT_LO, DONE, ABORT} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic [CNT_W-1:0]       cnt;
  logic [2:0]             idx;
  logic [1:0]             res_q;
  logic [4:0]             nt_q;
  logic [31:0]            sum_q;
  logic [7:0]             frame_byte;

  assign ack_s = ack_sync[SYNC_STAGES-1];

`ifdef PI_RESULT_TX_CHECKSUM_EN
  logic [7:0] csum;
  assign csum = SYNC_BYTE + {6'b0, res_q} + {3'b0, nt_q}
              + sum_q[31:24] + sum_q[23:16] + sum_q[15:8] + sum_q[7:0];
`endif

  // Frame bytes come from the captured payload, never the live classifier outputs.
  always_comb begin
    frame_byte = 8'h00;
    case (idx)
      3'd0: frame_byte = SYNC_BYTE;
      3'd1: frame_byte = {6'b0, res_q};
      3'd2: frame_byte = {3'b0, nt_q};
      3'd3: frame_byte = sum_q[31:24];
      3'd4: frame_byte = sum_q[23:16];
      3'd5: frame_byte = sum_q[15:8];
      3'd6: frame_byte = sum_q[7:0];
`ifdef PI_RESULT_TX_CHECKSUM_EN
      3'd7: frame_byte = csum;
`endif
      default: frame_byte = 8'h00;
    endcase
  end

  always_ff @(posedge fpga_clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ack_sync    <= '0;
      cnt         <= '0;
      idx         <= 3'd0;
      res_q       <= 2'b0;
      nt_q        <= 5'b0;
      sum_q       <= 32'b0;
      byte_output <= 8'h00;
      tx_strobe   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], pi_ack};
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            res_q       <= result;
            nt_q        <= num_transitions;
            sum_q       <= sum_left;
            timeout_err <= 1'b0;
            idx         <= 3'd0;
            busy        <= 1'b1;
            state       <= LOAD;
          end
        end
        LOAD: begin
          byte_output <= frame_byte;
          cnt         <= '0;
          state       <= SETUP;
        end
        SETUP: begin
          if (cnt == CNT_W'(SETUP_CYCLES - 1)) begin
            tx_strobe <= 1'b1;
            cnt       <= '0;
            state     <= WAIT_HI;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_HI: begin
          if (ack_s) begin
            tx_strobe <= 1'b0;
            cnt       <= '0;
            state     <= WAIT_LO;
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state <= ABORT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_LO: begin
          if (!ack_s) begin
            if (idx == LAST_IDX) begin
              state <= DONE;
            end else begin
              idx   <= idx + 3'd1;
              state <= LOAD;
            end
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state <= ABORT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          done        <= 1'b1;
          busy        <= 1'b0;
          byte_output <= 8'h00;
          state       <= IDLE;
        end
        ABORT: begin
          tx_strobe   <= 1'b0;
          byte_output <= 8'h00;
          timeout_err <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pi_result_tx.sv
// Randomized bench for pi_result_tx with a Pi ack model and a queue-based frame reference.
module tb_pi_result_tx;
  localparam int SETUP   = 4;
  localparam int TIMEOUT = 50;
  localparam int SS      = 2;
`ifdef PI_RESULT_TX_CHECKSUM_EN
  localparam int NB = 8;
`else
  localparam int NB = 7;
`endif

  logic        fpga_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  result = 2'b0;
  logic [4:0]  num_transitions = 5'b0;
  logic [31:0] sum_left = 32'b0;
  logic        pi_ack = 1'b0;
  logic [7:0]  byte_output;
  logic        tx_strobe, busy, done, timeout_err;

  pi_result_tx #(.SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(TIMEOUT), .SYNC_STAGES(SS), .SYNC_BYTE(8'hA5)) dut (
    .fpga_clk(fpga_clk), .rst_n(rst_n), .start(start), .result(result),
    .num_transitions(num_transitions), .sum_left(sum_left), .pi_ack(pi_ack),
    .byte_output(byte_output), .tx_strobe(tx_strobe), .busy(busy), .done(done),
    .timeout_err(timeout_err)
  );

  always #5 fpga_clk = ~fpga_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pi model: 0 echoes strobe ack_dly cycles late, 1 never acks, 2 acks once and never releases.
  int          ack_mode = 0;
  int          ack_dly = 3;
  logic [15:0] hist = '0;
  always @(posedge fpga_clk) begin
    #1;
    hist = {hist[14:0], tx_strobe};
    if (ack_mode == 0) pi_ack = hist[ack_dly];
    else if (ack_mode == 1) pi_ack = 1'b0;
    else if (tx_strobe) pi_ack = 1'b1;
  end

  logic [7:0] rx[$];
  logic [7:0] exp_q[$];
  int         rises = 0;
  int         done_cnt = 0;
  int         stable = 0;
  logic       prev_strobe = 1'b0;
  logic       prev_done = 1'b0;
  logic [7:0] prev_byte = 8'h00;

  always @(negedge fpga_clk) begin
    stable = (byte_output == prev_byte) ? stable + 1 : 0;
    if (tx_strobe && !prev_strobe) begin
      rx.push_back(byte_output);
      rises++;
      chk("setup_time", (stable >= SETUP) ? 32'd1 : 32'd0, 32'd1);
    end
    if (tx_strobe && prev_strobe) chk("hold_while_strobe", 32'(byte_output), 32'(prev_byte));
    if (done && !prev_done) done_cnt++;
    if (done) chk("done_one_cycle", 32'(prev_done), 32'd0);
    prev_strobe = tx_strobe;
    prev_done   = done;
    prev_byte   = byte_output;
  end

  task automatic model_frame(input logic [1:0] r, input logic [4:0] n, input logic [31:0] s);
    int total;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(r));
    exp_q.push_back(8'(n));
    exp_q.push_back(8'(s / 32'h0100_0000));
    exp_q.push_back(8'((s / 32'h0001_0000) % 256));
    exp_q.push_back(8'((s / 32'h0000_0100) % 256));
    exp_q.push_back(8'(s % 256));
    total = 0;
    foreach (exp_q[i]) total += int'(exp_q[i]);
    if (NB == 8) exp_q.push_back(8'(total % 256));
  endtask

  task automatic pulse_start();
    @(negedge fpga_clk) start = 1'b1;
    @(negedge fpga_clk) start = 1'b0;
  endtask

  task automatic wait_end(output int n);
    n = 0;
    while (!(done || (!busy && timeout_err)) && n < 5000) begin
      @(negedge fpga_clk);
      n++;
    end
    if (n >= 5000) chk("end_wait_bound", 32'(n), 32'd0);
  endtask

  task automatic wait_rises(input int target);
    int k;
    k = 0;
    while (rises < target && k < 5000) begin
      @(negedge fpga_clk);
      k++;
    end
    if (k >= 5000) chk("strobe_wait_bound", 32'(rises), 32'(target));
  endtask

  task automatic send_frame(input string tag, input logic [1:0] r, input logic [4:0] n,
                            input logic [31:0] s, input bit poke, output int lat);
    int d0, r0, w;
    result = r; num_transitions = n; sum_left = s;
    model_frame(r, n, s);
    rx.delete();
    d0 = done_cnt;
    r0 = rises;
    pulse_start();
    chk({tag, "_terr_clr"}, 32'(timeout_err), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    result = 2'($urandom); num_transitions = 5'($urandom); sum_left = $urandom;
    if (poke) begin
      wait_rises(r0 + 4);
      start = 1'b1;
      @(negedge fpga_clk) start = 1'b0;
    end
    wait_end(w);
    lat = w + 1;
    repeat (2) @(negedge fpga_clk);
    chk({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_terr"}, 32'(timeout_err), 32'd0);
    chk({tag, "_len"}, 32'(rx.size()), 32'(exp_q.size()));
    foreach (exp_q[i])
      if (i < rx.size()) chk($sformatf("%s_b%0d", tag, i), 32'(rx[i]), 32'(exp_q[i]));
    repeat (4) @(negedge fpga_clk);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic abort_case(input string tag, input int mode);
    int d0, w;
    ack_mode = mode;
    rx.delete();
    d0 = done_cnt;
    pulse_start();
    wait_end(w);
    repeat (2) @(negedge fpga_clk);
    chk({tag, "_terr"}, 32'(timeout_err), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_strobe"}, 32'(tx_strobe), 32'd0);
    chk({tag, "_byte"}, 32'(byte_output), 32'd0);
    chk({tag, "_no_done"}, 32'(done_cnt - d0), 32'd0);
    chk({tag, "_bytes_sent"}, 32'(rx.size()), 32'd1);
    ack_mode = 0;
    repeat (10) @(negedge fpga_clk);
  endtask

  initial begin
    int lat, r0;
    rst_n = 1'b0;
    repeat (3) @(negedge fpga_clk);
    chk("rst_byte", 32'(byte_output), 32'd0);
    chk("rst_strobe", 32'(tx_strobe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge fpga_clk);

    ack_mode = 0; ack_dly = 3;
    send_frame("fixed", 2'b10, 5'd4, 32'h0000_04B1, 1'b0, lat);

    for (int i = 0; i < 6; i++) begin
      ack_dly = $urandom_range(0, 5);
      send_frame($sformatf("rand%0d", i), 2'($urandom_range(0, 2)), 5'($urandom), $urandom,
                 (i % 2) == 1, lat);
    end

    ack_dly = 0;
    repeat (4) @(negedge fpga_clk);
    send_frame("instant", 2'b01, 5'd31, 32'hDEAD_BEEF, 1'b0, lat);
    chk("latency", 32'(lat), 32'(NB * (SETUP + 3 + 2 * SS) + 2));

    ack_dly = 2;
    abort_case("no_ack", 1);
    abort_case("stuck_ack", 2);
    chk("terr_sticky", 32'(timeout_err), 32'd1);
    send_frame("after_abort", 2'b00, 5'd17, 32'h1234_5678, 1'b0, lat);

    // Reset during the third byte's strobe.
    ack_dly = 3;
    result = 2'b10; num_transitions = 5'd9; sum_left = 32'hCAFE_0001;
    r0 = rises;
    pulse_start();
    wait_rises(r0 + 3);
    rst_n = 1'b0;
    @(negedge fpga_clk) rst_n = 1'b1;
    chk("midrst_byte", 32'(byte_output), 32'd0);
    chk("midrst_strobe", 32'(tx_strobe), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_terr", 32'(timeout_err), 32'd0);
    repeat (10) @(negedge fpga_clk);
    chk("midrst_idle", 32'(busy | tx_strobe), 32'd0);
    send_frame("after_rst", 2'b10, 5'd9, 32'hCAFE_0001, 1'b1, lat);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule
